// File: rtl/logical_op_sequencer_if.sv
// Switch/button inputs, logical-unit operands/result and status outputs of the sequencer.
// master is the sequencer's side; slave is the board/logical-unit side.
interface logical_op_sequencer_if #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned COUNT_W = 8
);
    logic                  start;
    logic                  load;
    logic [DATA_W-1:0]     data_in;
    logic [1:0]            sel_in;
    logic [DATA_W-1:0]     X;
    logic [DATA_W-1:0]     Y;
    logic [1:0]            sel;
    logic [2*DATA_W-1:0]   result;
    logic [2*DATA_W-1:0]   result_reg;
    logic                  busy;
    logic                  done;
    logic [2:0]            state_out;
    logic [COUNT_W-1:0]    op_count;

    modport master (
        input  start, load, data_in, sel_in, result,
        output X, Y, sel, result_reg, busy, done, state_out, op_count
    );

    modport slave (
        output start, load, data_in, sel_in, result,
        input  X, Y, sel, result_reg, busy, done, state_out, op_count
    );
endinterface

// File: rtl/logical_op_sequencer.sv
// Collects X, Y and the function select from switches over load presses, drives the
// logical unit with registered operands, captures its result and counts operations.
module logical_op_sequencer #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned COUNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    logical_op_sequencer_if.master   bus
);
    localparam int unsigned RES_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_X   = 3'd1,
        GET_Y   = 3'd2,
        GET_SEL = 3'd3,
        ISSUE   = 3'd4,
        CAPTURE = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 start_q;
    logic                 load_q;
    logic                 start_rise;
    logic                 load_rise;
    logic                 take_x;
    logic                 take_y;
    logic                 take_sel;
    logic                 take_res;
    logic [DATA_W-1:0]    x_r;
    logic [DATA_W-1:0]    y_r;
    logic [1:0]           sel_r;
    logic [RES_W-1:0]     res_r;
    logic [COUNT_W-1:0]   cnt_r;

    // Edge registers follow the buttons even during reset, so a button still held
    // when reset is released does not register as a fresh press.
    always_ff @(posedge clk) begin
        start_q <= bus.start;
        load_q  <= bus.load;
    end

    assign start_rise = bus.start & ~start_q;
    assign load_rise  = bus.load  & ~load_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load wins over start in the GET states because start is ignored there
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_rise) state_next = GET_X;
            GET_X:   if (load_rise)  state_next = GET_Y;
            GET_Y:   if (load_rise)  state_next = GET_SEL;
            GET_SEL: if (load_rise)  state_next = ISSUE;
            ISSUE:                   state_next = CAPTURE;
            CAPTURE:                 state_next = DONE;
            DONE:    if (start_rise) state_next = GET_X;
            default:                 state_next = IDLE;
        endcase
    end

    // Datapath load strobes decoded from state and button events
    always_comb begin
        take_x   = 1'b0;
        take_y   = 1'b0;
        take_sel = 1'b0;
        take_res = 1'b0;
        case (state)
            GET_X:   take_x   = load_rise;
            GET_Y:   take_y   = load_rise;
            GET_SEL: take_sel = load_rise;
            CAPTURE: take_res = 1'b1;
            default: ;
        endcase
    end

    // Operand, select, result and counter registers; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r   <= '0;
            y_r   <= '0;
            sel_r <= '0;
            res_r <= '0;
            cnt_r <= '0;
        end else begin
            if (take_x)   x_r   <= bus.data_in;
            if (take_y)   y_r   <= bus.data_in;
            if (take_sel) sel_r <= bus.sel_in;
            if (take_res) begin
                res_r <= bus.result;
                cnt_r <= cnt_r + COUNT_W'(1);
            end
        end
    end

    assign bus.X          = x_r;
    assign bus.Y          = y_r;
    assign bus.sel        = sel_r;
    assign bus.result_reg = res_r;
    assign bus.op_count   = cnt_r;
    assign bus.state_out  = state;
    assign bus.busy       = (state >= GET_X) && (state <= CAPTURE);
    assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_logical_op_sequencer.sv
// Randomized bench for logical_op_sequencer with the logical unit modelled in place;
// a second instance with a 2-bit counter shares the stimulus to exercise counter wrap.
module tb_logical_op_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logical_op_sequencer_if #(.DATA_W(4), .COUNT_W(8)) ifa ();
    logical_op_sequencer_if #(.DATA_W(4), .COUNT_W(2)) ifb ();

    logical_op_sequencer #(.DATA_W(4), .COUNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.master)
    );

    logical_op_sequencer #(.DATA_W(4), .COUNT_W(2)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.master)
    );

    // Logical unit: AND/OR/XOR zero-extended, NOT inverts {Y,X}
    function automatic logic [7:0] logic_unit(input logic [3:0] x, input logic [3:0] y,
                                              input logic [1:0] s);
        case (s)
            2'd0:    return {4'h0, x & y};
            2'd1:    return {4'h0, x | y};
            2'd2:    return {4'h0, x ^ y};
            default: return ~{y, x};
        endcase
    endfunction

    assign ifa.result  = logic_unit(ifa.X, ifa.Y, ifa.sel);
    assign ifb.result  = logic_unit(ifb.X, ifb.Y, ifb.sel);
    assign ifb.start   = ifa.start;
    assign ifb.load    = ifa.load;
    assign ifb.data_in = ifa.data_in;
    assign ifb.sel_in  = ifa.sel_in;

    // Reference model of what a completed operation should produce
    int exp_state;
    int exp_x;
    int exp_y;
    int exp_sel;
    int exp_res;
    int exp_cnt;

    function automatic int ref_result(input int x, input int y, input int s);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            int xb = (x >> b) & 1;
            int yb = (y >> b) & 1;
            case (s)
                0: r += (xb * yb) << b;
                1: r += ((xb + yb > 0) ? 1 : 0) << b;
                2: r += ((xb + yb) % 2) << b;
                default: ;
            endcase
        end
        if (s == 3) r = 255 - (y * 16 + x);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},  32'(ifa.state_out),  32'(exp_state));
        check({tag, ".busy"},   32'(ifa.busy),       32'((exp_state >= 1 && exp_state <= 5) ? 1 : 0));
        check({tag, ".done"},   32'(ifa.done),       32'((exp_state == 6) ? 1 : 0));
        check({tag, ".x"},      32'(ifa.X),          32'(exp_x));
        check({tag, ".y"},      32'(ifa.Y),          32'(exp_y));
        check({tag, ".sel"},    32'(ifa.sel),        32'(exp_sel));
        check({tag, ".res"},    32'(ifa.result_reg), 32'(exp_res));
        check({tag, ".cnt"},    32'(ifa.op_count),   32'(exp_cnt % 256));
        check({tag, ".cnt2"},   32'(ifb.op_count),   32'(exp_cnt % 4));
        check({tag, ".state2"}, 32'(ifb.state_out),  32'(exp_state));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_state = 0;
        exp_x     = 0;
        exp_y     = 0;
        exp_sel   = 0;
        exp_res   = 0;
        exp_cnt   = 0;
    endtask

    // One full operation with optional held button and ignored/simultaneous events
    task automatic run_op(input int x, input int y, input int s, input int hold_x,
                          input bit start_in_y, input bit both_on_y, input bit load_in_done);
        ifa.start = 1'b1;
        cyc();
        exp_state = 1;
        check_all("start");
        ifa.start = 1'b0;
        cyc();
        check_all("start_rel");

        ifa.data_in = 4'(x);
        ifa.load    = 1'b1;
        cyc();
        exp_x     = x;
        exp_state = 2;
        check_all("load_x");
        for (int i = 0; i < hold_x; i++) begin
            ifa.data_in = 4'($urandom);
            cyc();
            check_all("hold_x");
        end
        ifa.load    = 1'b0;
        ifa.data_in = 4'($urandom);
        cyc();
        check_all("rel_x");

        if (start_in_y) begin
            ifa.start = 1'b1;
            cyc();
            check_all("ign_start");
            ifa.start = 1'b0;
            cyc();
            check_all("ign_start_rel");
        end

        ifa.data_in = 4'(y);
        ifa.load    = 1'b1;
        if (both_on_y) ifa.start = 1'b1;
        cyc();
        exp_y     = y;
        exp_state = 3;
        check_all("load_y");
        ifa.load  = 1'b0;
        ifa.start = 1'b0;
        cyc();
        check_all("rel_y");

        ifa.sel_in = 2'(s);
        ifa.load   = 1'b1;
        cyc();
        exp_sel   = s;
        exp_state = 4;
        check_all("issue");
        ifa.load   = 1'b0;
        ifa.sel_in = 2'($urandom);
        cyc();
        exp_state = 5;
        check_all("capture");
        cyc();
        exp_state = 6;
        exp_res   = ref_result(x, y, s);
        exp_cnt++;
        check_all("done");

        if (load_in_done) begin
            ifa.load    = 1'b1;
            ifa.data_in = 4'($urandom);
            cyc();
            check_all("ign_load_done");
            ifa.load = 1'b0;
            cyc();
            check_all("ign_load_done_rel");
        end
    endtask

    initial begin
        reset       = 1'b1;
        ifa.start   = 1'b0;
        ifa.load    = 1'b0;
        ifa.data_in = '0;
        ifa.sel_in  = '0;
        model_clear();

        // Reset with both buttons held; release must not produce an event
        ifa.start = 1'b1;
        ifa.load  = 1'b1;
        cyc();
        cyc();
        check_all("reset");
        reset = 1'b0;
        cyc();
        check_all("reset_rel_held");
        ifa.start = 1'b0;
        ifa.load  = 1'b0;
        cyc();
        check_all("idle");

        // Load in IDLE is ignored
        ifa.load    = 1'b1;
        ifa.data_in = 4'h7;
        cyc();
        check_all("ign_load_idle");
        ifa.load = 1'b0;
        cyc();

        run_op(4'hC, 4'hA, 0, 0, 1'b0, 1'b0, 1'b0);
        check("and_result", 32'(ifa.result_reg), 32'h08);
        check("and_count",  32'(ifa.op_count),   32'd1);

        run_op(4'hC, 4'hA, 3, 0, 1'b0, 1'b0, 1'b0);
        check("not_result", 32'(ifa.result_reg), 32'h53);
        check("not_count",  32'(ifa.op_count),   32'd2);

        run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1, 5, 1'b1, 1'b1, 1'b1);

        // Reset in GET_SEL aborts the operation
        ifa.start = 1'b1;
        cyc();
        ifa.start = 1'b0;
        ifa.data_in = 4'h5;
        ifa.load = 1'b1;
        cyc();
        ifa.load = 1'b0;
        cyc();
        ifa.data_in = 4'h9;
        ifa.load = 1'b1;
        cyc();
        ifa.load = 1'b0;
        cyc();
        exp_state = 3;
        exp_x = 5;
        exp_y = 9;
        check_all("pre_midrst");
        reset = 1'b1;
        cyc();
        model_clear();
        check_all("midrst");
        reset = 1'b0;
        cyc();
        check_all("midrst_rel");

        // Five operations from a cleared counter: 2-bit copy runs 1,2,3,0,1
        for (int n = 0; n < 5; n++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 0, 1'b0, 1'b0, 1'b0);
        end
        check("wrap_final", 32'(ifb.op_count), 32'd1);

        for (int n = 0; n < 12; n++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
